// File: rtl/hex_display_arbiter.sv
// ---------------------------------------------------------------------------
// hex_display_arbiter: round-robin sharing of the HEX0 display, slot + blank gap
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hex_display_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [4*NUM_REQ-1:0]   DIGIT,
  output logic [NUM_REQ-1:0]     GRANT,
  output logic [NUM_REQ-1:0]     DONE,
  output logic                   BUSY,
  output logic [6:0]             HEX0
);

  localparam int c_MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC) + 1;
  localparam int c_PTR_W   = $clog2(NUM_REQ);

  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [c_PTR_W-1:0] c_LAST_IDX  = c_PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] c_ONE       = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [6:0]         c_BLANK     = 7'b1111111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [c_PTR_W-1:0] ptr_q,   ptr_d;
  logic [c_PTR_W-1:0] idx_q,   idx_d;
  logic [c_CNT_W-1:0] cnt_q,   cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q,  done_d;
  logic [6:0]         hex_q,   hex_d;

  logic               w_found;
  logic [c_PTR_W-1:0] w_winner;
  logic [3:0]         w_win_digit;
  logic [3:0]         w_own_digit;
  logic               w_own_req;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  endfunction

  // Scan from the farthest offset down so the offset nearest ptr wins.
  always_comb begin
    int j;
    j        = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (REQ[j[c_PTR_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = j[c_PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_win_digit = '0;
    w_own_digit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == i[c_PTR_W-1:0]) w_win_digit = DIGIT[4*i +: 4];
      if (idx_q == i[c_PTR_W-1:0])    w_own_digit = DIGIT[4*i +: 4];
    end
  end

  assign w_own_req = REQ[idx_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = '0;
    hex_d   = hex_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        hex_d   = c_BLANK;
        cnt_d   = '0;
        if (w_found) begin
          grant_d = c_ONE << w_winner;
          idx_d   = w_winner;
          hex_d   = seg(w_win_digit);
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        hex_d = seg(w_own_digit);
        cnt_d = cnt_q + 1'b1;
        if (!w_own_req || cnt_q == c_HOLD_LAST) begin
          grant_d = '0;
          hex_d   = c_BLANK;
          cnt_d   = '0;
          ptr_d   = (idx_q == c_LAST_IDX) ? '0 : idx_q + 1'b1;
          // Reaching here with the request still high means a clean expiry.
          if (w_own_req) done_d = c_ONE << idx_q;
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        grant_d = '0;
        hex_d   = c_BLANK;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == c_GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        hex_d   = c_BLANK;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      hex_q   <= c_BLANK;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      hex_q   <= hex_d;
    end
  end

  assign GRANT = grant_q;
  assign DONE  = done_q;
  assign HEX0  = hex_q;
  assign BUSY  = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_hex_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hex_display_arbiter: self-checking bench with a slot/gap reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hex_display_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 4;
  localparam int GAP  = 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req   = 4'b0000;
  logic [15:0] digit = 16'h0000;
  logic [3:0]  GRANT, DONE;
  logic        BUSY;
  logic [6:0]  HEX0;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the display, how many clocks it has had,
  // how many blank gap clocks remain, and where the next scan starts.
  int         m_owner = -1;
  int         m_used  = 0;
  int         m_gap   = 0;
  int         m_ptr   = 0;
  logic [3:0] e_grant = 4'b0000;
  logic [3:0] e_done  = 4'b0000;
  logic       e_busy  = 1'b0;
  logic [6:0] e_hex   = 7'b1111111;

  wire [15:0] w_obs = {GRANT, DONE, BUSY, HEX0};
  wire [15:0] w_exp = {e_grant, e_done, e_busy, e_hex};

  hex_display_arbiter #(
    .NUM_REQ     (N),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .REQ      (req),
    .DIGIT    (digit),
    .GRANT    (GRANT),
    .DONE     (DONE),
    .BUSY     (BUSY),
    .HEX0     (HEX0)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    logic [6:0] tab [16];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tab[v];
  endfunction

  function automatic logic [3:0] nib(input int i);
    return 4'(digit >> (4 * i));
  endfunction

  task automatic model_step();
    int cand;
    e_done = 4'b0000;
    if (!rst_n) begin
      m_owner = -1; m_used = 0; m_gap = 0; m_ptr = 0;
      e_hex   = 7'b1111111;
    end else if (m_owner >= 0) begin
      if (!req[m_owner[1:0]] || m_used == HOLD) begin
        if (req[m_owner[1:0]]) e_done[m_owner[1:0]] = 1'b1;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = GAP;
        e_hex   = 7'b1111111;
      end else begin
        m_used++;
        e_hex = seg_ref(nib(m_owner));
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 0; k < N; k++) begin
        cand = (m_ptr + k) % N;
        if (m_owner < 0 && req[cand[1:0]]) begin
          m_owner = cand;
          m_used  = 1;
          e_hex   = seg_ref(nib(cand));
        end
      end
    end
    e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e_busy  = (m_owner >= 0) || (m_gap > 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req   = 4'b1111;
    digit = 16'h4321;
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if (w_obs !== {4'b0000, 4'b0000, 1'b0, 7'b1111111}) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", w_obs, {4'b0000, 4'b0000, 1'b0, 7'b1111111});
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (GRANT !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_grant got=%b exp=0001", GRANT);
    end
    total++;
    if (w_obs !== w_exp) begin
      bad++;
      $display("FAIL reset_model got=%h exp=%h", w_obs, w_exp);
    end
  endtask

  task automatic test_single_owner();
    logic [3:0] g_hist [14];
    logic [3:0] d_hist [14];
    logic [3:0] g_want [7];
    logic [3:0] d_want [7];
    req   = 4'b0001;
    digit = 16'h0003;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick();
      g_hist[i] = GRANT;
      d_hist[i] = DONE;
      total++;
      if (w_obs !== w_exp) begin
        bad++;
        $display("FAIL single_model cyc=%0d got=%h exp=%h", i, w_obs, w_exp);
      end
      if (i < 4) begin
        total++;
        if (HEX0 !== 7'b0110000) begin
          bad++;
          $display("FAIL single_hex cyc=%0d got=%b exp=0110000", i, HEX0);
        end
      end
    end
    g_want = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    d_want = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      total++;
      if (g_hist[i] !== g_want[i] || d_hist[i] !== d_want[i]) begin
        bad++;
        $display("FAIL single_timeline cyc=%0d got g=%b d=%b exp g=%b d=%b",
                 i, g_hist[i], d_hist[i], g_want[i], d_want[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] grants [$];
    logic [3:0] dones  [$];
    logic [3:0] g_want [5];
    logic [3:0] prev;
    req   = 4'b1111;
    digit = 16'hFA73;
    do_reset();
    prev = 4'b0000;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (GRANT != 4'b0000 && prev == 4'b0000) grants.push_back(GRANT);
      if (DONE != 4'b0000) dones.push_back(DONE);
      prev = GRANT;
      total++;
      if (w_obs !== w_exp) begin
        bad++;
        $display("FAIL rr_model cyc=%0d got=%h exp=%h", i, w_obs, w_exp);
      end
    end
    g_want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= grants.size() || grants[i] !== g_want[i]) begin
        bad++;
        $display("FAIL rr_grant_order slot=%0d got=%b exp=%b", i,
                 (i < grants.size()) ? grants[i] : 4'b0000, g_want[i]);
      end
      if (i < 4) begin
        total++;
        if (i >= dones.size() || dones[i] !== g_want[i]) begin
          bad++;
          $display("FAIL rr_done_order slot=%0d got=%b exp=%b", i,
                   (i < dones.size()) ? dones[i] : 4'b0000, g_want[i]);
        end
      end
    end
  endtask

  task automatic test_early_drop();
    bit found;
    req   = 4'b1111;
    digit = 16'h8C2E;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      total++;
      if (w_obs !== w_exp) begin
        bad++;
        $display("FAIL drop_model cyc=%0d got=%h exp=%h", i, w_obs, w_exp);
      end
      if (GRANT == 4'b0100) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL drop_wait_owner2 got=%b exp=0100", GRANT);
    end
    tick();
    req = 4'b1011;
    tick();
    total++;
    if (GRANT !== 4'b0000 || DONE !== 4'b0000 || w_obs !== w_exp) begin
      bad++;
      $display("FAIL drop_release got g=%b d=%b exp g=0000 d=0000", GRANT, DONE);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      total++;
      if (w_obs !== w_exp) begin
        bad++;
        $display("FAIL drop_after_model cyc=%0d got=%h exp=%h", i, w_obs, w_exp);
      end
      if (GRANT != 4'b0000) found = 1'b1;
    end
    total++;
    if (GRANT !== 4'b1000) begin
      bad++;
      $display("FAIL drop_next_owner got=%b exp=1000", GRANT);
    end
  endtask

  task automatic test_live_digit();
    req   = 4'b0010;
    digit = 16'h0050;
    do_reset();
    tick();
    total++;
    if (GRANT !== 4'b0010 || HEX0 !== 7'b0010010) begin
      bad++;
      $display("FAIL live_first got g=%b hex=%b exp g=0010 hex=0010010", GRANT, HEX0);
    end
    digit[7:4] = 4'hA;
    digit[3:0] = 4'($urandom);
    tick();
    total++;
    if (HEX0 !== 7'b0001000 || w_obs !== w_exp) begin
      bad++;
      $display("FAIL live_change got=%b exp=0001000", HEX0);
    end
    digit[3:0] = ~digit[3:0];
    tick();
    total++;
    if (HEX0 !== 7'b0001000 || w_obs !== w_exp) begin
      bad++;
      $display("FAIL live_nonowner got=%b exp=0001000", HEX0);
    end
  endtask

  task automatic test_reset_mid_slot();
    req   = 4'b0010;
    digit = 16'h9B61;
    do_reset();
    tick();
    tick();
    total++;
    if (GRANT !== 4'b0010) begin
      bad++;
      $display("FAIL midrst_owner got=%b exp=0010", GRANT);
    end
    rst_n = 1'b0;
    req   = 4'b1111;
    tick();
    total++;
    if (w_obs !== {4'b0000, 4'b0000, 1'b0, 7'b1111111}) begin
      bad++;
      $display("FAIL midrst_abort got=%h exp=%h", w_obs, {4'b0000, 4'b0000, 1'b0, 7'b1111111});
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (GRANT !== 4'b0001 || w_obs !== w_exp) begin
      bad++;
      $display("FAIL midrst_regrant got=%b exp=0001", GRANT);
    end
  endtask

  task automatic test_random();
    req   = 4'b0000;
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      digit = 16'($urandom);
      rst_n = ($urandom_range(0, 79) != 0);
      tick();
      total++;
      if (w_obs !== w_exp) begin
        bad++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", i, w_obs, w_exp);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_owner();
    test_round_robin();
    test_early_drop();
    test_live_digit();
    test_reset_mid_slot();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
